// File: rtl/aes128_mode_cipher.sv
// ---------------------------------------------------------------------------
// aes128_mode_cipher
// Five-mode AES-128 block engine (ECB, CBC, CFB-128, OFB, CTR) wrapped
// around an iterative single-block AES-128 encrypt core (aes128_core).
//
// Ports (top):
//   clk_sys   in   1    rising-edge clock
//   rst_n     in   1    asynchronous active-low reset (also resets the core)
//   cfg_mode  in   3    0 ECB, 1 CBC, 2 CFB, 3 OFB, 4 CTR, 5-7 illegal
//   cfg_dec   in   1    decrypt select (CFB/OFB/CTR only)
//   cfg_key   in   128  cipher key, captured at input accept
//   iv        in   128  initial chaining value / counter
//   iv_load   in   1    chain <= iv, honoured only in IDLE
//   in_valid  in   1    / in_ready out 1 / in_data in 128 : input block stream
//   out_valid out  1    / out_ready in 1 / out_data out 128 : result stream
//   out_err   out  1    result belongs to an illegal block (data forced to 0)
//
// aes128_core: cipher_en pulse loads key/plain_text; ten rounds run one per
// cycle and cipher_text is presented with a one-cycle cipher_ready pulse ten
// cycles after cipher_en.
// ---------------------------------------------------------------------------
module aes128_core (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] cipher_key,
   input  logic [127:0] plain_text,
   input  logic         cipher_en,
   output logic [127:0] cipher_text,
   output logic         cipher_ready
);

   // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         else      p = p;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (x^254, which also maps 0 to 0) then affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
             {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] rc;
      case (rnd)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   // One key-schedule step: previous round key -> next round key
   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t;
      logic [31:0] n0;
      logic [31:0] n1;
      logic [31:0] n2;
      logic [31:0] n3;
      t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
      n0 = k[127:96] ^ t;
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // SubBytes, ShiftRows, MixColumns (skipped in the last round), AddRoundKey.
   // Byte i of the block is row i%4, column i/4.
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   m [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) t[r + 4*c] = b[r + 4*((c + r) % 4)];
      end
      for (int c = 0; c < 4; c++) begin
         m[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
         m[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
         m[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
         m[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = (last ? t[i] : m[i]) ^ rk[127-8*i -: 8];
      return o;
   endfunction

   logic [127:0] state_q;
   logic [127:0] rk_q;
   logic [3:0]   rnd_q;
   logic         busy_q;
   logic [127:0] text_q;
   logic         ready_q;
   logic [127:0] rk_next_s;
   logic [127:0] round_s;
   logic         last_s;

   // Round datapath for the round number held in rnd_q
   always_comb begin
      rk_next_s = next_key(rk_q, rcon(rnd_q));
      last_s    = (rnd_q == 4'd10);
      round_s   = aes_round(state_q, rk_next_s, last_s);
   end

   // Iterative round sequencer; cipher_ready is a one-cycle pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= 128'd0;
         rk_q    <= 128'd0;
         rnd_q   <= 4'd0;
         busy_q  <= 1'b0;
         text_q  <= 128'd0;
         ready_q <= 1'b0;
      end else if (cipher_en) begin
         state_q <= plain_text ^ cipher_key;
         rk_q    <= cipher_key;
         rnd_q   <= 4'd1;
         busy_q  <= 1'b1;
         ready_q <= 1'b0;
      end else if (busy_q) begin
         state_q <= round_s;
         rk_q    <= rk_next_s;
         rnd_q   <= rnd_q + 4'd1;
         if (last_s) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            text_q  <= round_s;
         end else begin
            ready_q <= 1'b0;
         end
      end else begin
         ready_q <= 1'b0;
      end
   end

   assign cipher_text  = text_q;
   assign cipher_ready = ready_q;

endmodule

module aes128_mode_cipher #(
   parameter logic [4:0] MODE_MASK = 5'b11111,
   parameter int         CTR_W     = 128
) (
   input  logic         clk_sys,
   input  logic         rst_n,
   input  logic [2:0]   cfg_mode,
   input  logic         cfg_dec,
   input  logic [127:0] cfg_key,
   input  logic [127:0] iv,
   input  logic         iv_load,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         out_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_OUTP  = 2'd3
   } state_t;

   localparam logic [2:0] M_ECB = 3'd0;
   localparam logic [2:0] M_CBC = 3'd1;
   localparam logic [2:0] M_CFB = 3'd2;
   localparam logic [2:0] M_OFB = 3'd3;
   localparam logic [2:0] M_CTR = 3'd4;

   // Bits of the chain that take part in the counter increment
   localparam logic [127:0] CTR_MASK = (CTR_W >= 128) ? {128{1'b1}} :
                                       ((128'd1 << CTR_W) - 128'd1);

   function automatic logic mode_legal(input logic [2:0] mode, input logic dec);
      logic ok;
      case (mode)
         M_ECB:   ok = MODE_MASK[0] & ~dec;
         M_CBC:   ok = MODE_MASK[1] & ~dec;
         M_CFB:   ok = MODE_MASK[2];
         M_OFB:   ok = MODE_MASK[3];
         M_CTR:   ok = MODE_MASK[4];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   state_t       state_q, state_d;
   logic [127:0] din_q, din_d;
   logic [2:0]   mode_q, mode_d;
   logic         dec_q, dec_d;
   logic [127:0] key_q, key_d;
   logic [127:0] chain_q, chain_d;
   logic [127:0] out_data_q, out_data_d;
   logic         out_err_q, out_err_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;

   logic [127:0] core_in_s;
   logic [127:0] ks_s;
   logic         cipher_ready_s;
   logic         cipher_en_s;
   logic [127:0] chain_inc_s;

   assign cipher_en_s = (state_q == S_START);
   // Counter step: low CTR_W bits wrap, upper bits never see a carry
   assign chain_inc_s = ((chain_q + 128'd1) & CTR_MASK) | (chain_q & ~CTR_MASK);

   aes128_core u_core (
      .clk          (clk_sys),
      .rst_n        (rst_n),
      .cipher_key   (key_q),
      .plain_text   (core_in_s),
      .cipher_en    (cipher_en_s),
      .cipher_text  (ks_s),
      .cipher_ready (cipher_ready_s)
   );

   // Block fed to the core for the captured mode
   always_comb begin
      case (mode_q)
         M_ECB:   core_in_s = din_q;
         M_CBC:   core_in_s = din_q ^ chain_q;
         default: core_in_s = chain_q;
      endcase
   end

   // Next-state, capture, result and chain logic
   always_comb begin
      state_d    = state_q;
      din_d      = din_q;
      mode_d     = mode_q;
      dec_d      = dec_q;
      key_d      = key_q;
      chain_d    = chain_q;
      out_data_d = out_data_q;
      out_err_d  = out_err_q;
      case (state_q)
         S_IDLE: begin
            // The IV lands on the same edge as an accept, so START sees it
            if (iv_load) chain_d = iv;
            else         chain_d = chain_q;
            if (in_valid && in_ready_q) begin
               if (mode_legal(cfg_mode, cfg_dec)) begin
                  din_d   = in_data;
                  mode_d  = cfg_mode;
                  dec_d   = cfg_dec;
                  key_d   = cfg_key;
                  state_d = S_START;
               end else begin
                  out_data_d = 128'd0;
                  out_err_d  = 1'b1;
                  state_d    = S_OUTP;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            if (cipher_ready_s) begin
               out_err_d = 1'b0;
               state_d   = S_OUTP;
               case (mode_q)
                  M_ECB: begin
                     out_data_d = ks_s;
                     chain_d    = chain_q;
                  end
                  M_CBC: begin
                     out_data_d = ks_s;
                     chain_d    = ks_s;
                  end
                  M_CFB: begin
                     out_data_d = ks_s ^ din_q;
                     chain_d    = dec_q ? din_q : (ks_s ^ din_q);
                  end
                  M_OFB: begin
                     out_data_d = ks_s ^ din_q;
                     chain_d    = ks_s;
                  end
                  M_CTR: begin
                     out_data_d = ks_s ^ din_q;
                     chain_d    = chain_inc_s;
                  end
                  default: begin
                     out_data_d = 128'd0;
                     out_err_d  = 1'b1;
                     chain_d    = chain_q;
                  end
               endcase
            end else begin
               state_d = S_WAIT;
            end
         end
         S_OUTP: begin
            if (out_ready) state_d = S_IDLE;
            else           state_d = S_OUTP;
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_OUTP);
   end

   // State, capture and output registers
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         din_q       <= 128'd0;
         mode_q      <= 3'd0;
         dec_q       <= 1'b0;
         key_q       <= 128'd0;
         chain_q     <= 128'd0;
         out_data_q  <= 128'd0;
         out_err_q   <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         din_q       <= din_d;
         mode_q      <= mode_d;
         dec_q       <= dec_d;
         key_q       <= key_d;
         chain_q     <= chain_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_aes128_mode_cipher.sv
// ---------------------------------------------------------------------------
// tb_aes128_mode_cipher
// Two instances share stimulus: dut_a (all modes, 128-bit counter) and
// dut_b (OFB disabled, 32-bit counter). A byte-array AES-128 model with
// per-instance chain values predicts every result; a negedge compare process
// checks each valid output cycle against the expectation queues.
// ---------------------------------------------------------------------------
module tb_aes128_mode_cipher;

   logic         clk_sys = 1'b0;
   logic         rst_n;
   logic [2:0]   cfg_mode;
   logic         cfg_dec;
   logic [127:0] cfg_key;
   logic [127:0] iv;
   logic         iv_load;
   logic         in_valid;
   logic [127:0] in_data;
   logic         out_ready;
   logic         in_ready_a, out_valid_a, out_err_a;
   logic [127:0] out_data_a;
   logic         in_ready_b, out_valid_b, out_err_b;
   logic [127:0] out_data_b;

   always #5 clk_sys = ~clk_sys;

   aes128_mode_cipher dut_a (
      .clk_sys(clk_sys), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_dec(cfg_dec),
      .cfg_key(cfg_key), .iv(iv), .iv_load(iv_load), .in_valid(in_valid),
      .in_ready(in_ready_a), .in_data(in_data), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_data(out_data_a), .out_err(out_err_a));

   aes128_mode_cipher #(.MODE_MASK(5'b10111), .CTR_W(32)) dut_b (
      .clk_sys(clk_sys), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_dec(cfg_dec),
      .cfg_key(cfg_key), .iv(iv), .iv_load(iv_load), .in_valid(in_valid),
      .in_ready(in_ready_b), .in_data(in_data), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_data(out_data_b), .out_err(out_err_b));

   int           checks = 0;
   int           errors = 0;
   logic [128:0] q_a[$];
   logic [128:0] q_b[$];
   logic [127:0] ch_a, ch_b;
   logic [7:0]   sb [256];

   localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] IVC = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

   task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic finish_sim();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Polynomial multiply then reduce modulo 0x11b
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      logic [15:0] poly;
      p    = 16'h0000;
      poly = 16'h011b;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (poly << (i - 8));
      return p[7:0];
   endfunction

   // Textbook AES-128 encryption on a 4x4 byte state
   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h000000};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sb[s[r][(c+r)%4]];
         for (int c = 0; c < 4; c++) begin
            if (rnd < 10) begin
               s[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
               s[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
               s[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
               s[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
            end else begin
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end
            for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
         end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127-8*(4*c+r) -: 8] = s[r][c];
      return res;
   endfunction

   // Mode behaviour of one block; returns {err, data} and advances the chain
   task automatic model(input logic [4:0] mask, input int ctrw, input logic [2:0] mode,
                        input logic dec, input logic [127:0] key, input logic [127:0] d,
                        inout logic [127:0] ch, output logic [128:0] res);
      logic         legal;
      logic [127:0] ks;
      if (mode > 3'd4) legal = 1'b0;
      else             legal = mask[mode] && !(dec && mode <= 3'd1);
      if (!legal) begin
         res = {1'b1, 128'd0};
      end else begin
         case (mode)
            3'd0: begin ks = aes_enc(key, d);      res = {1'b0, ks}; end
            3'd1: begin ks = aes_enc(key, d ^ ch); res = {1'b0, ks}; ch = ks; end
            3'd2: begin ks = aes_enc(key, ch); res = {1'b0, ks ^ d}; ch = dec ? d : (ks ^ d); end
            3'd3: begin ks = aes_enc(key, ch); res = {1'b0, ks ^ d}; ch = ks; end
            default: begin
               ks  = aes_enc(key, ch);
               res = {1'b0, ks ^ d};
               if (ctrw == 128) ch = ch + 128'd1;
               else             ch = {ch[127:32], ch[31:0] + 32'd1};
            end
         endcase
      end
   endtask

   // Drive one block, then complete its output handshake after 'hold' stalled cycles
   task automatic send(input logic [2:0] mode, input logic dec, input logic [127:0] key,
                       input logic [127:0] d, input logic ld, input logic [127:0] ivv,
                       input int hold, output logic [127:0] exp_o);
      logic [128:0] ea, eb;
      int           n;
      n = 0;
      @(negedge clk_sys);
      while (!in_ready_a && n < 100) begin @(negedge clk_sys); n++; end
      if (!in_ready_a) begin
         chk("in_ready_wait", {128'd0, in_ready_a}, 129'd1);
         finish_sim();
      end
      @(posedge clk_sys); #1;
      cfg_mode = mode; cfg_dec = dec; cfg_key = key; in_data = d;
      iv = ivv; iv_load = ld; in_valid = 1'b1; out_ready = (hold == 0);
      if (ld) begin ch_a = ivv; ch_b = ivv; end
      model(5'b11111, 128, mode, dec, key, d, ch_a, ea);
      model(5'b10111, 32, mode, dec, key, d, ch_b, eb);
      q_a.push_back(ea);
      q_b.push_back(eb);
      exp_o = ea[127:0];
      @(posedge clk_sys); #1;
      in_valid = 1'b0; iv_load = 1'b0;
      cfg_mode = 3'($urandom); cfg_dec = 1'($urandom); cfg_key = rand128();
      in_data = rand128(); iv = rand128();
      n = 0;
      @(negedge clk_sys);
      while (!out_valid_a && n < 100) begin @(negedge clk_sys); n++; end
      chk("latency", 129'(n), ea[128] ? 129'd0 : 129'd12);
      if (!out_valid_a) finish_sim();
      if (hold > 0) begin
         repeat (hold) @(negedge clk_sys);
         @(posedge clk_sys); #1;
         out_ready = 1'b1;
         @(negedge clk_sys);
      end
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk("in_ready_after_hs", {128'd0, in_ready_a}, 129'd1);
      chk("drained", 129'(q_a.size() + q_b.size()), 129'd0);
   endtask

   // Output checker: every valid cycle, including stalled ones
   always @(negedge clk_sys) begin
      if (rst_n) begin
         if (out_valid_a) begin
            if (q_a.size() == 0) chk("spurious_a", {128'd0, out_valid_a}, 129'd0);
            else begin
               chk("out_a", {out_err_a, out_data_a}, q_a[0]);
               chk("in_ready_busy_a", {128'd0, in_ready_a}, 129'd0);
               if (out_ready) q_a.delete(0);
            end
         end
         if (out_valid_b) begin
            if (q_b.size() == 0) chk("spurious_b", {128'd0, out_valid_b}, 129'd0);
            else begin
               chk("out_b", {out_err_b, out_data_b}, q_b[0]);
               if (out_ready) q_b.delete(0);
            end
         end
      end
   end

   initial begin
      #2000000;
      chk("watchdog", {128'd0, out_valid_a}, 129'd2);
      finish_sim();
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_a"}, {in_ready_a, out_valid_a, out_err_a, out_data_a[125:0]}, 129'd0);
      chk({tag, "_b"}, {in_ready_b, out_valid_b, out_err_b, out_data_b[125:0]}, 129'd0);
      chk({tag, "_dhi"}, {125'd0, out_data_a[127:126], out_data_b[127:126]}, 129'd0);
   endtask

   initial begin
      logic [127:0] e;
      logic [7:0]   inv, xb, sv, c63;
      rst_n = 1'b0; cfg_mode = 3'd0; cfg_dec = 1'b0; cfg_key = 128'd0; iv = 128'd0;
      iv_load = 1'b0; in_valid = 1'b0; in_data = 128'd0; out_ready = 1'b1;
      ch_a = 128'd0; ch_b = 128'd0;
      c63 = 8'h63;
      for (int x = 0; x < 256; x++) begin
         xb  = x[7:0];
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
         for (int i = 0; i < 8; i++)
            sv[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
         sb[x] = sv;
      end
      chk("sbox_00", {121'd0, sb[0]}, 129'h63);
      chk("sbox_53", {121'd0, sb[8'h53]}, 129'hed);

      repeat (3) @(negedge clk_sys);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk_sys);
      chk("in_ready_rise", {127'd0, in_ready_a, in_ready_b}, 129'd3);

      send(3'd0, 1'b0, K, P1, 1'b0, 128'd0, 0, e);
      chk("ecb_vec", {1'b0, e}, {1'b0, 128'h3ad77bb40d7a3660a89ecaf32466ef97});
      send(3'd1, 1'b0, K, P1, 1'b1, IV0, 0, e);
      chk("cbc_vec1", {1'b0, e}, {1'b0, 128'h7649abac8119b246cee98e9b12e9197d});
      send(3'd1, 1'b0, K, P2, 1'b0, 128'd0, 1, e);
      chk("cbc_vec2", {1'b0, e}, {1'b0, 128'h5086cb9b507219ee95db113a917678b2});
      send(3'd2, 1'b0, K, P1, 1'b1, IV0, 0, e);
      chk("cfb_vec", {1'b0, e}, {1'b0, 128'h3b3fd92eb72dad20333449f8e83cfb4a});
      send(3'd3, 1'b0, K, P1, 1'b1, IV0, 0, e);
      chk("ofb_vec", {1'b0, e}, {1'b0, 128'h3b3fd92eb72dad20333449f8e83cfb4a});
      send(3'd3, 1'b1, K, 128'h3b3fd92eb72dad20333449f8e83cfb4a, 1'b1, IV0, 0, e);
      chk("ofb_dec", {1'b0, e}, {1'b0, P1});
      send(3'd4, 1'b0, K, P1, 1'b1, IVC, 0, e);
      chk("ctr_vec", {1'b0, e}, {1'b0, 128'h874d6191b620e3261bef6864990db6ce});

      // Counter wrap: dut_a carries into bit 32, dut_b keeps the upper 96 bits
      send(3'd4, 1'b0, K, P1, 1'b1, {96'h0123456789abcdef01234567, 32'hffffffff}, 0, e);
      send(3'd4, 1'b0, K, P2, 1'b0, 128'd0, 0, e);
      send(3'd4, 1'b0, K, P2, 1'b0, 128'd0, 0, e);

      // Illegal blocks must leave the chain alone; the CTR block afterwards shows it
      send(3'd0, 1'b1, K, P1, 1'b0, 128'd0, 0, e);
      send(3'd6, 1'b0, K, P1, 1'b0, 128'd0, 2, e);
      send(3'd4, 1'b0, K, P1, 1'b0, 128'd0, 0, e);

      // Backpressure
      send(3'd0, 1'b0, K, P1, 1'b0, 128'd0, 5, e);

      // Reset while the core is busy
      @(negedge clk_sys);
      while (!in_ready_a) @(negedge clk_sys);
      @(posedge clk_sys); #1;
      cfg_mode = 3'd1; cfg_dec = 1'b0; cfg_key = K; in_data = P1; in_valid = 1'b1;
      @(posedge clk_sys); #1;
      in_valid = 1'b0;
      repeat (5) @(negedge clk_sys);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      q_a.delete(); q_b.delete();
      ch_a = 128'd0; ch_b = 128'd0;
      repeat (2) @(negedge clk_sys);
      rst_n = 1'b1;
      @(negedge clk_sys);
      chk("in_ready_rise2", {128'd0, in_ready_a}, 129'd1);
      send(3'd4, 1'b0, K, P1, 1'b0, 128'd0, 0, e);

      for (int n = 0; n < 40; n++) begin
         send(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), rand128(), rand128(),
              ($urandom_range(0, 2) == 0), rand128(), $urandom_range(0, 3), e);
      end

      repeat (3) @(negedge clk_sys);
      finish_sim();
   end

endmodule
